// File: rtl/seq_controller.sv
// CPU sequencer: fetches a 16-bit instruction in three steps and then decodes it into the
// bus/ALU/register strobes for a variable number of execute steps. Also handles halt/run and interrupt entry.
module seq_controller #(
  parameter int          DATA_W    = 16,
  parameter int          REG_SEL_W = 3,
  parameter int          FLAG_W    = 4,
  parameter int          LINK_REG  = 1,
  parameter logic [11:0] IRQ_VEC   = 12'h0F0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    in,
  input  logic [FLAG_W-1:0]    flags,
  input  logic                 run,
  input  logic                 irq,
  output logic [3:0]           alu_opcode,
  output logic                 alu_out_en,
  output logic                 alu_ar_flag,
  output logic                 mem_addr_en,
  output logic                 mem_in_en,
  output logic                 mem_out_en,
  output logic                 reg_in_en,
  output logic                 reg_pc_en,
  output logic                 reg_jp_en,
  output logic                 reg_br_en,
  output logic                 reg_out_en,
  output logic                 ctl_out_en,
  output logic                 dsp_in_en,
  output logic [REG_SEL_W-1:0] reg_src_sel,
  output logic [REG_SEL_W-1:0] reg_dst_sel,
  output logic [DATA_W-1:0]    out,
  output logic [2:0]           step,
  output logic                 halted,
  output logic                 irq_ack
);

  typedef enum logic [1:0] {S_RUN, S_HALT, S_IRQ0, S_IRQ1} state_e;

  state_e      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [15:0] inst_q, inst_d;

  logic [3:0] opc, sub;
  logic       immf, indf;
  logic [2:0] dstf, srcf;
  logic       br_take, is_hlt, last;
  logic       alu_fin, alu_cmp;
  logic [2:0] alu_fsrc;

  assign opc     = inst_q[15:12];
  assign sub     = inst_q[11:8];
  assign immf    = inst_q[11];
  assign dstf    = inst_q[10:8];
  assign indf    = inst_q[7];
  assign srcf    = inst_q[6:4];
  assign br_take = flags[dstf[2:1]] ^ dstf[0];
  assign is_hlt  = (opc == 4'h0) && (sub == 4'hF);
  assign step    = step_q;
  assign halted  = (state_q == S_HALT);

  always_comb begin
    alu_opcode  = '0;
    alu_out_en  = 1'b0;
    alu_ar_flag = 1'b0;
    mem_addr_en = 1'b0;
    mem_in_en   = 1'b0;
    mem_out_en  = 1'b0;
    reg_in_en   = 1'b0;
    reg_pc_en   = 1'b0;
    reg_jp_en   = 1'b0;
    reg_br_en   = 1'b0;
    reg_out_en  = 1'b0;
    ctl_out_en  = 1'b0;
    dsp_in_en   = 1'b0;
    reg_src_sel = '0;
    reg_dst_sel = '0;
    irq_ack     = 1'b0;
    last        = 1'b0;
    alu_fin     = 1'b0;
    alu_cmp     = 1'b0;
    alu_fsrc    = srcf;
    if ((opc == 4'hC) || (opc == 4'hD)) out = DATA_W'(inst_q[11:0]);
    else                                out = DATA_W'(inst_q[7:0]);

    case (state_q)
      S_HALT: ;
      S_IRQ0: begin
        reg_out_en  = 1'b1;
        reg_in_en   = 1'b1;
        reg_dst_sel = REG_SEL_W'(LINK_REG);
      end
      S_IRQ1: begin
        out        = DATA_W'(IRQ_VEC);
        ctl_out_en = 1'b1;
        reg_jp_en  = 1'b1;
        irq_ack    = 1'b1;
      end
      default: begin
        if (step_q == 3'd0) begin
          reg_out_en  = 1'b1;
          mem_addr_en = 1'b1;
        end else if (step_q == 3'd1) begin
          mem_out_en = 1'b1;
          reg_pc_en  = 1'b1;
        end else if (step_q >= 3'd3) begin
          case (opc)
            4'h0: begin
              if (sub == 4'h2) begin
                if (!indf) begin
                  reg_src_sel = REG_SEL_W'(srcf);
                  reg_out_en  = 1'b1;
                  dsp_in_en   = 1'b1;
                  last        = 1'b1;
                end else if (step_q == 3'd3) begin
                  reg_src_sel = REG_SEL_W'(srcf);
                  reg_out_en  = 1'b1;
                  mem_addr_en = 1'b1;
                end else begin
                  mem_out_en = 1'b1;
                  dsp_in_en  = 1'b1;
                  last       = 1'b1;
                end
              end else begin
                last = 1'b1;
              end
            end
            4'h1: begin
              if (immf) begin
                ctl_out_en  = 1'b1;
                reg_in_en   = 1'b1;
                reg_dst_sel = REG_SEL_W'(dstf);
                last        = 1'b1;
              end else if (!indf) begin
                reg_src_sel = REG_SEL_W'(srcf);
                reg_out_en  = 1'b1;
                reg_in_en   = 1'b1;
                reg_dst_sel = REG_SEL_W'(dstf);
                last        = 1'b1;
              end else if (step_q == 3'd3) begin
                reg_src_sel = REG_SEL_W'(srcf);
                reg_out_en  = 1'b1;
                mem_addr_en = 1'b1;
              end else begin
                mem_out_en  = 1'b1;
                reg_in_en   = 1'b1;
                reg_dst_sel = REG_SEL_W'(dstf);
                last        = 1'b1;
              end
            end
            4'h2: begin
              // The address comes from the dst field, the stored data from src.
              reg_out_en = 1'b1;
              if (step_q == 3'd3) begin
                reg_src_sel = REG_SEL_W'(dstf);
                mem_addr_en = 1'b1;
              end else begin
                reg_src_sel = REG_SEL_W'(srcf);
                mem_in_en   = 1'b1;
                last        = 1'b1;
              end
            end
            4'hA, 4'hB: begin
              alu_opcode  = opc;
              alu_ar_flag = immf;
              if (indf && (step_q == 3'd3)) begin
                reg_src_sel = REG_SEL_W'(srcf);
                reg_out_en  = 1'b1;
                mem_addr_en = 1'b1;
              end else begin
                alu_fin = 1'b1;
              end
            end
            4'hC: begin
              ctl_out_en = 1'b1;
              reg_jp_en  = 1'b1;
              last       = 1'b1;
            end
            4'hD: begin
              if (step_q == 3'd3) begin
                reg_out_en  = 1'b1;
                reg_in_en   = 1'b1;
                reg_dst_sel = REG_SEL_W'(LINK_REG);
              end else begin
                ctl_out_en = 1'b1;
                reg_jp_en  = 1'b1;
                last       = 1'b1;
              end
            end
            4'hF: begin
              if ((step_q == 3'd3) && !br_take) begin
                last = 1'b1;
              end else if ((step_q == 3'd3) && immf) begin
                ctl_out_en = 1'b1;
                reg_br_en  = 1'b1;
                last       = 1'b1;
              end else if ((step_q == 3'd3) && !indf) begin
                reg_src_sel = REG_SEL_W'(srcf);
                reg_out_en  = 1'b1;
                reg_br_en   = 1'b1;
                last        = 1'b1;
              end else if (step_q == 3'd3) begin
                reg_src_sel = REG_SEL_W'(srcf);
                reg_out_en  = 1'b1;
                mem_addr_en = 1'b1;
              end else begin
                mem_out_en = 1'b1;
                reg_br_en  = 1'b1;
                last       = 1'b1;
              end
            end
            default: begin
              // Two-operand ALU ops and CMP; r7 stages an immediate or memory operand.
              alu_cmp    = (opc == 4'hE);
              alu_opcode = alu_cmp ? 4'd4 : opc;
              if (immf) begin
                if (step_q == 3'd3) begin
                  ctl_out_en  = 1'b1;
                  reg_in_en   = 1'b1;
                  reg_dst_sel = REG_SEL_W'(3'd7);
                end else begin
                  alu_fin  = 1'b1;
                  alu_fsrc = 3'd7;
                end
              end else if (indf) begin
                if (step_q == 3'd3) begin
                  reg_src_sel = REG_SEL_W'(srcf);
                  reg_out_en  = 1'b1;
                  mem_addr_en = 1'b1;
                end else if (step_q == 3'd4) begin
                  mem_out_en  = 1'b1;
                  reg_in_en   = 1'b1;
                  reg_dst_sel = REG_SEL_W'(3'd7);
                end else begin
                  alu_fin  = 1'b1;
                  alu_fsrc = 3'd7;
                end
              end else begin
                alu_fin = 1'b1;
              end
            end
          endcase
          if (alu_fin) begin
            alu_out_en  = 1'b1;
            reg_src_sel = REG_SEL_W'(alu_fsrc);
            reg_in_en   = !alu_cmp;
            reg_dst_sel = alu_cmp ? '0 : REG_SEL_W'(dstf);
            last        = 1'b1;
          end
          if (step_q >= 3'd5) last = 1'b1;
        end
      end
    endcase

    if (!rst) begin
      alu_opcode  = '0;
      alu_out_en  = 1'b0;
      alu_ar_flag = 1'b0;
      mem_addr_en = 1'b0;
      mem_in_en   = 1'b0;
      mem_out_en  = 1'b0;
      reg_in_en   = 1'b0;
      reg_pc_en   = 1'b0;
      reg_jp_en   = 1'b0;
      reg_br_en   = 1'b0;
      reg_out_en  = 1'b0;
      ctl_out_en  = 1'b0;
      dsp_in_en   = 1'b0;
      reg_src_sel = '0;
      reg_dst_sel = '0;
      irq_ack     = 1'b0;
      out         = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    inst_d  = inst_q;
    case (state_q)
      S_RUN: begin
        if (step_q == 3'd2) inst_d = in[15:0];
        if (last) begin
          // HLT wins over a pending irq; the irq is taken from HALT next cycle.
          step_d = 3'd0;
          if (is_hlt)   state_d = S_HALT;
          else if (irq) state_d = S_IRQ0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      S_HALT: begin
        step_d = 3'd0;
        if (irq)      state_d = S_IRQ0;
        else if (run) state_d = S_RUN;
      end
      S_IRQ0: begin
        step_d  = 3'd0;
        state_d = S_IRQ1;
      end
      default: begin
        step_d  = 3'd0;
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_RUN;
      step_q  <= 3'd0;
      inst_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      inst_q  <= inst_d;
    end
  end

endmodule

// File: tb/tb_seq_controller.sv
// Bench for seq_controller: a table of single instructions checked at their last step,
// followed by hand-written halt, interrupt and reset sequences.
module tb_seq_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] in_w = 16'h0000;
  logic [3:0]  flags = 4'h0;
  logic        run = 1'b0;
  logic        irq = 1'b0;

  logic [3:0]  alu_opcode;
  logic        alu_out_en, alu_ar_flag, mem_addr_en, mem_in_en, mem_out_en, reg_in_en;
  logic        reg_pc_en, reg_jp_en, reg_br_en, reg_out_en, ctl_out_en, dsp_in_en;
  logic [2:0]  reg_src_sel, reg_dst_sel;
  logic [15:0] out;
  logic [2:0]  step;
  logic        halted, irq_ack;

  seq_controller dut (
    .clk(clk), .rst(rst), .in(in_w), .flags(flags), .run(run), .irq(irq),
    .alu_opcode(alu_opcode), .alu_out_en(alu_out_en), .alu_ar_flag(alu_ar_flag),
    .mem_addr_en(mem_addr_en), .mem_in_en(mem_in_en), .mem_out_en(mem_out_en),
    .reg_in_en(reg_in_en), .reg_pc_en(reg_pc_en), .reg_jp_en(reg_jp_en),
    .reg_br_en(reg_br_en), .reg_out_en(reg_out_en), .ctl_out_en(ctl_out_en),
    .dsp_in_en(dsp_in_en), .reg_src_sel(reg_src_sel), .reg_dst_sel(reg_dst_sel),
    .out(out), .step(step), .halted(halted), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] ALU = 12'h800, AR = 12'h400, MADDR = 12'h200, MIN = 12'h100;
  localparam logic [11:0] MOUT = 12'h080, RIN = 12'h040, PC = 12'h020, JP = 12'h010;
  localparam logic [11:0] BR = 12'h008, ROUT = 12'h004, CTL = 12'h002, DSP = 12'h001;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [15:0] w;
    logic [3:0]  f;
    int          len;
    logic [11:0] s;
    int          dst;
    int          src;
    int          outv;
    int          aop;
  } vec_t;

  vec_t tbl[17];

  function automatic logic [11:0] stb();
    return {alu_out_en, alu_ar_flag, mem_addr_en, mem_in_en, mem_out_en, reg_in_en,
            reg_pc_en, reg_jp_en, reg_br_en, reg_out_en, ctl_out_en, dsp_in_en};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  // Runs one instruction from step 0 and returns the outputs seen on its last step.
  task automatic run_inst(input logic [15:0] w, input logic [3:0] f, output int len,
                          output logic [11:0] s, output int dst, output int src,
                          output int outv, output int aop, output logic [11:0] s0);
    in_w = w;
    flags = f;
    #1;
    s0 = stb();
    len = 0;
    s = '0; dst = 0; src = 0; outv = 0; aop = 0;
    for (int i = 0; i < 12; i++) begin
      s    = stb();
      dst  = int'(reg_dst_sel);
      src  = int'(reg_src_sel);
      outv = int'(out);
      aop  = int'(alu_opcode);
      len++;
      tick();
      if (step == 3'd0) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int          len, dst, src, outv, aop, err;
    logic [11:0] s, s0;

    tbl[0]  = '{16'h1A05, 4'h0, 4, CTL | RIN,        2, 0, 16'h05,  0};
    tbl[1]  = '{16'h1230, 4'h0, 4, ROUT | RIN,       2, 3, 16'h30,  0};
    tbl[2]  = '{16'h12B0, 4'h0, 5, MOUT | RIN,       2, 0, 16'hB0,  0};
    tbl[3]  = '{16'h2130, 4'h0, 5, ROUT | MIN,       0, 3, 16'h30,  0};
    tbl[4]  = '{16'h31A0, 4'h0, 6, ALU | RIN,        1, 7, 16'hA0,  3};
    tbl[5]  = '{16'h5320, 4'h0, 4, ALU | RIN,        3, 2, 16'h20,  5};
    tbl[6]  = '{16'h4A07, 4'h0, 5, ALU | RIN,        2, 7, 16'h07,  4};
    tbl[7]  = '{16'hE120, 4'h0, 4, ALU,              0, 2, 16'h20,  4};
    tbl[8]  = '{16'hA940, 4'h0, 4, ALU | AR | RIN,   1, 4, 16'h40, 10};
    tbl[9]  = '{16'hC123, 4'h0, 4, CTL | JP,         0, 0, 16'h123, 0};
    tbl[10] = '{16'hD456, 4'h0, 5, CTL | JP,         0, 0, 16'h456, 0};
    tbl[11] = '{16'hF800, 4'h0, 4, 12'h000,          0, 0, 16'h00,  0};
    tbl[12] = '{16'hF800, 4'h1, 4, CTL | BR,         0, 0, 16'h00,  0};
    tbl[13] = '{16'hF3A0, 4'h0, 5, MOUT | BR,        0, 0, 16'hA0,  0};
    tbl[14] = '{16'h0250, 4'h0, 4, ROUT | DSP,       0, 5, 16'h50,  0};
    tbl[15] = '{16'h02D0, 4'h0, 5, MOUT | DSP,       0, 0, 16'hD0,  0};
    tbl[16] = '{16'h0000, 4'h0, 4, 12'h000,          0, 0, 16'h00,  0};

    // Reset state
    rst = 1'b0;
    repeat (3) tick();
    chk("reset_step", int'(step), 0);
    chk("reset_halted", int'(halted), 0);
    chk("reset_strobes", int'(stb()), 0);
    chk("reset_irq_ack", int'(irq_ack), 0);
    rst = 1'b1;
    #1;
    chk("release_fetch0", int'(stb()), int'(ROUT | MADDR));

    // ALU indirect, intermediate steps
    in_w = 16'h31A0;
    tick();
    chk("fetch1_strobes", int'(stb()), int'(MOUT | PC));
    tick();
    chk("fetch2_strobes", int'(stb()), 0);
    tick();
    chk("alui_s3_strobes", int'(stb()), int'(ROUT | MADDR));
    chk("alui_s3_src", int'(reg_src_sel), 2);
    tick();
    chk("alui_s4_strobes", int'(stb()), int'(MOUT | RIN));
    chk("alui_s4_dst", int'(reg_dst_sel), 7);
    tick();
    chk("alui_s5_step", int'(step), 5);
    tick();
    chk("alui_end_step", int'(step), 0);

    // HLT then run resume
    in_w = 16'h0F00;
    repeat (3) tick();
    chk("hlt_s3_strobes", int'(stb()), 0);
    tick();
    err = 0;
    for (int i = 0; i < 10; i++) begin
      if (!halted || stb() != 12'h000 || step != 3'd0) err++;
      tick();
    end
    chk("halt_hold_errors", err, 0);
    run = 1'b1;
    tick();
    run = 1'b0;
    #1;
    chk("resume_halted", int'(halted), 0);
    chk("resume_step", int'(step), 0);
    chk("resume_fetch0", int'(stb()), int'(ROUT | MADDR));

    // irq during ALU direct, held through the entry sequence
    in_w = 16'h3120;
    irq = 1'b1;
    repeat (3) tick();
    chk("irq_alu_s3", int'(stb()), int'(ALU | RIN));
    tick();
    chk("irq0_strobes", int'(stb()), int'(ROUT | RIN));
    chk("irq0_dst", int'(reg_dst_sel), 1);
    chk("irq0_src", int'(reg_src_sel), 0);
    tick();
    chk("irq1_strobes", int'(stb()), int'(CTL | JP));
    chk("irq1_out", int'(out), 16'h0F0);
    chk("irq1_ack", int'(irq_ack), 1);
    irq = 1'b0;
    tick();
    chk("post_irq_step", int'(step), 0);
    chk("post_irq_fetch0", int'(stb()), int'(ROUT | MADDR));
    chk("post_irq_ack", int'(irq_ack), 0);
    repeat (4) tick();
    chk("no_retake_step", int'(step), 0);
    chk("no_retake_strobes", int'(stb()), int'(ROUT | MADDR));

    // HLT with irq pending, then irq beats run in HALT
    in_w = 16'h0F00;
    irq = 1'b1;
    repeat (4) tick();
    chk("hlt_irq_halted", int'(halted), 1);
    run = 1'b1;
    tick();
    chk("halt_irq0_halted", int'(halted), 0);
    chk("halt_irq0_strobes", int'(stb()), int'(ROUT | RIN));
    irq = 1'b0;
    run = 1'b0;
    tick();
    chk("halt_irq1_ack", int'(irq_ack), 1);
    tick();
    chk("halt_irq_done_step", int'(step), 0);

    // Reset in the middle of JSR
    in_w = 16'hD456;
    repeat (4) tick();
    chk("jsr_s4_strobes", int'(stb()), int'(CTL | JP));
    rst = 1'b0;
    #1;
    chk("jsr_rst_strobes", int'(stb()), 0);
    tick();
    chk("jsr_rst_step", int'(step), 0);
    chk("jsr_rst_halted", int'(halted), 0);
    rst = 1'b1;
    #1;
    chk("jsr_release_fetch0", int'(stb()), int'(ROUT | MADDR));

    // Table of instructions, checked at their final step
    for (int k = 0; k < 17; k++) begin
      run_inst(tbl[k].w, tbl[k].f, len, s, dst, src, outv, aop, s0);
      chk($sformatf("v%0d_fetch0", k), int'(s0), int'(ROUT | MADDR));
      chk($sformatf("v%0d_len", k), len, tbl[k].len);
      chk($sformatf("v%0d_strobes", k), int'(s), int'(tbl[k].s));
      chk($sformatf("v%0d_dst", k), dst, tbl[k].dst);
      chk($sformatf("v%0d_src", k), src, tbl[k].src);
      chk($sformatf("v%0d_out", k), outv, tbl[k].outv);
      chk($sformatf("v%0d_aop", k), aop, tbl[k].aop);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_controller.md
Name: seq_controller

Overview:
Parametrised successor to the tiny16 instruction controller. It contains its own step counter and FSM, so no external step module is needed. It drives the same bus/ALU/register control strobes, with these changes:
- variable-length instructions (each ends at its last active step)
- a working indirect ST
- HLT with run-resume
- a single-level interrupt entry sequence

It sits between memory/register file/ALU and the data bus, as the CPU sequencer.

Parameters:
DATA_W, 16, bus width; instruction occupies in[15:0] (DATA_W >= 16)
REG_SEL_W, 3, register select width (>= 3)
FLAG_W, 4, flag input width (>= 4; branches use flags[3:0])
LINK_REG, 1, register receiving saved PC on JSR/interrupt
IRQ_VEC, 12'h0F0, interrupt jump target driven on out

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-low
in  in  DATA_W  bus input (instruction fetch)
flags  in  FLAG_W  ALU flags, sampled combinationally
run  in  1  resume pulse from halt
irq  in  1  level interrupt request
alu_opcode  out  4  ALU operation
alu_out_en, alu_ar_flag, mem_addr_en, mem_in_en, mem_out_en, reg_in_en, reg_pc_en, reg_jp_en, reg_br_en, reg_out_en, ctl_out_en, dsp_in_en  out  1 each  control strobes
reg_src_sel, reg_dst_sel  out  REG_SEL_W  register selects (3-bit fields zero-extended)
out  out  DATA_W  immediate: inst[11:0] for JMP/JSR, IRQ_VEC during IRQ1, else inst[7:0]; zero-extended
step  out  3  current step
halted  out  1  halt state
irq_ack  out  1  one-cycle interrupt acknowledge

Behaviour:
- Registered state: state {RUN, HALT, IRQ0, IRQ1}, step[2:0], inst[15:0]. All outputs are combinational decode of registered state, inst and flags.
- Control outputs default to 0 every cycle and are forced to 0 whenever rst=0.
- Reset (rst=0 at edge): state=RUN, step=0, inst=0, halted=0, irq_ack=0. Reset mid-instruction aborts the instruction; the first cycle after release is step 0.
- Fetch:
  - step0: reg_src_sel=0, reg_out_en, mem_addr_en.
  - step1: mem_out_en, reg_pc_en.
  - step2: no strobes; inst<=in[15:0] at the end of the cycle.
- Fields: opcode=inst[15:12], imm=[11], dst=[10:8], ind=[7], src=[6:4].
- Execute (last step in brackets; the step after the last step is 0):
  - NOP/IN/SET/CLR/other SYS [3]: no strobes.
  - OUT [3 direct / 4 indirect]: direct → reg_out_en+dsp_in_en at step 3. Indirect → step3 reg_out_en+mem_addr_en, step4 mem_out_en+dsp_in_en. src selected.
  - HLT [3]: state→HALT at end of step 3.
  - LD [3 / 4 indirect]:
    - imm: ctl_out_en+reg_in_en.
    - direct: reg_out_en+reg_in_en.
    - indirect: step3 addr from src, step4 mem_out_en+reg_in_en into dst.
  - ST [4]: step3 reg_src_sel=dst, reg_out_en, mem_addr_en; step4 reg_src_sel=src, reg_out_en, mem_in_en.
  - 3–9 ALU, alu_opcode=opcode:
    - direct [3]: alu_out_en+reg_in_en.
    - imm [4]: step3 ctl_out_en → r7; step4 src=r7, alu_out_en, reg_in_en.
    - indirect [5]: step3 addr; step4 mem → r7; step5 ALU from r7.
  - 10–11 shift/rotate: alu_ar_flag=imm; direct [3], indirect [4], same strobes as ALU direct.
  - JMP [3]: ctl_out_en, reg_jp_en, dst_sel=0.
  - JSR [4]: step3 PC → LINK_REG; step4 ctl_out_en+reg_jp_en.
  - CMP (14): as ALU with alu_opcode=4 and no reg_in_en on the final ALU step; lengths 3/4/5.
  - BR (15): cond = flags[dst[2:1]] XOR dst[0].
    - Not taken: no strobes, ends at 3.
    - Taken: reg_br_en with imm→ctl_out_en [3], direct→reg_out_en [3], indirect→step3 addr, step4 mem_out_en [4].
- Instruction boundary: last step of a RUN instruction. If irq=1, go to IRQ0; else step 0.
- IRQ0: reg_src_sel=0, reg_out_en, reg_dst_sel=LINK_REG, reg_in_en.
- IRQ1: out=IRQ_VEC, ctl_out_en, reg_jp_en, irq_ack=1, then RUN step 0. irq is ignored during IRQ0/IRQ1.
- HALT: halted=1, no strobes, step held 0.
  - irq=1 → IRQ0 (halted clears).
  - else run=1 → RUN step 0.
  - irq and run simultaneous: irq wins.
- HLT has priority over a pending irq: irq is serviced from HALT on the next cycle.
- step never exceeds 5; no wrap.

Test Plan:
- Reset, then fetch LD imm in=0x1A05 → step3: ctl_out_en=1, reg_in_en=1, reg_dst_sel=2, out=0x0005; next cycle step=0; total 4 cycles.
- ALU indirect in=0x31A0 → step3 reg_src_sel=2, mem_addr_en; step4 reg_dst_sel=7, mem_out_en; step5 reg_src_sel=7, alu_out_en, reg_in_en, reg_dst_sel=1, alu_opcode=3; 6 cycles total.
- BR 0xF800:
  - flags=0000 → no strobes at step3, next step 0.
  - flags=0001 → step3 ctl_out_en=1, reg_br_en=1, reg_dst_sel=0.
- HLT 0x0F00 → halted=1, all strobes 0 for 10 cycles; run pulse → next cycle step0 with reg_out_en, mem_addr_en.
- irq=1 during ALU direct 0x3120 → after step3: IRQ0 (PC→r1), then IRQ1 (out=0x0F0, reg_jp_en, irq_ack=1), then fetch; irq held one extra cycle is not re-taken mid-sequence.
- rst=0 at JSR step4 → strobes 0 while rst=0; after release step=0, halted=0, first fetch normal.
